// File: rtl/atom_npu_pkg.sv
// Shared types and arithmetic helpers for the NPU multiply-accumulate unit.
package atom_npu_pkg;

    // Datapath states of the MAC unit.
    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_MUL    = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_FINISH = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

    // Wide signed working width for saturation maths; every supported
    // ACC_W/OUT_W is well below this, so no intermediate can overflow.
    localparam int CALC_W = 64;

    typedef struct packed {
        logic              sat;
        logic [CALC_W-1:0] val;
    } sat_res_t;

    // Saturate a wide signed value into a w-bit range, signed or unsigned.
    function automatic sat_res_t saturate(
        input logic signed [CALC_W-1:0] v,
        input int                       w,
        input logic                     sgn
    );
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        sat_res_t                 r;
        if (sgn) begin
            hi = (64'sd1 <<< (w - 1)) - 64'sd1;
            lo = -(64'sd1 <<< (w - 1));
        end else begin
            hi = (64'sd1 <<< w) - 64'sd1;
            lo = 64'sd0;
        end
        if (v > hi) begin
            r.sat = 1'b1;
            r.val = hi;
        end else if (v < lo) begin
            r.sat = 1'b1;
            r.val = lo;
        end else begin
            r.sat = 1'b0;
            r.val = v;
        end
        return r;
    endfunction

    // Output stage: optional ReLU (signed only, never flags saturation),
    // followed by a clamp to the output width.
    function automatic sat_res_t clamp_relu(
        input logic signed [CALC_W-1:0] v,
        input int                       w,
        input logic                     sgn,
        input logic                     relu
    );
        logic signed [CALC_W-1:0] t;
        if (sgn && relu && (v < 64'sd0)) begin
            t = 64'sd0;
        end else begin
            t = v;
        end
        return saturate(t, w, sgn);
    endfunction

endpackage

// File: rtl/atom_npu_shift_mul.sv
// Serial shift-add magnitude multiplier: one multiplier bit per cycle,
// DATA_W cycles per product, pulse o_done on the final cycle.
module atom_npu_shift_mul #(
    parameter int DATA_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [DATA_W-1:0]     i_mag_d,
    input  logic [DATA_W-1:0]     i_mag_w,
    output logic [2*DATA_W-1:0]   o_partial,
    output logic                  o_done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]   r_mult;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [2*DATA_W-1:0] r_partial;
    logic                r_active;
    logic [2*DATA_W-1:0] w_shifted;

    assign w_shifted = {{DATA_W{1'b0}}, r_mcand} << r_bit_cnt;
    assign o_done    = r_active && (r_bit_cnt == CNT_W'(DATA_W - 1));
    assign o_partial = r_partial;

    // Load operands, then add the shifted multiplicand for each set multiplier bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= {DATA_W{1'b0}};
            r_mult    <= {DATA_W{1'b0}};
            r_bit_cnt <= {CNT_W{1'b0}};
            r_partial <= {(2*DATA_W){1'b0}};
            r_active  <= 1'b0;
        end else if (i_load) begin
            r_mcand   <= i_mag_d;
            r_mult    <= i_mag_w;
            r_bit_cnt <= {CNT_W{1'b0}};
            r_partial <= {(2*DATA_W){1'b0}};
            r_active  <= 1'b1;
        end else if (r_active) begin
            if (r_mult[0]) begin
                r_partial <= r_partial + w_shifted;
            end else begin
                r_partial <= r_partial;
            end
            r_mult    <= {1'b0, r_mult[DATA_W-1:1]};
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            r_active  <= !o_done;
        end else begin
            r_active  <= 1'b0;
        end
    end

endmodule

// File: rtl/atom_npu_mac_unit.sv
// Vector multiply-accumulate unit: serial products accumulated onto a bias,
// then optional ReLU and a saturating clamp, with valid/ready on both sides.
module atom_npu_mac_unit
    import atom_npu_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 16,
    parameter int OUT_W  = 4,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_weight,
    input  logic              in_last,
    input  logic [ACC_W-1:0]  bias_in,
    input  logic              relu_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat,
    output logic              busy
);

    state_t                   r_state;
    state_t                   w_next_state;
    logic                     r_first;
    logic                     r_sign;
    logic                     r_last;
    logic                     r_relu;
    logic                     r_sat;
    logic [ACC_W-1:0]         r_acc;
    logic [OUT_W-1:0]         r_out_data;
    logic                     r_out_sat;
    logic                     r_out_valid;

    logic                     w_accept;
    logic                     w_d_neg;
    logic                     w_w_neg;
    logic [DATA_W-1:0]        w_mag_d;
    logic [DATA_W-1:0]        w_mag_w;
    logic [2*DATA_W-1:0]      w_partial;
    logic                     w_mul_done;
    logic signed [CALC_W-1:0] w_acc_ext;
    logic signed [CALC_W-1:0] w_part_ext;
    logic signed [CALC_W-1:0] w_acc_sum;
    sat_res_t                 w_acc_res;
    sat_res_t                 w_out_res;
    logic                     w_unused;

    assign in_ready  = (r_state == ST_LOAD) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign busy      = (r_state != ST_LOAD);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;

    // Operand magnitudes; the most negative value maps to 2^(DATA_W-1),
    // which still fits in DATA_W unsigned bits.
    assign w_d_neg = (SIGNED != 0) && in_data[DATA_W-1];
    assign w_w_neg = (SIGNED != 0) && in_weight[DATA_W-1];
    assign w_mag_d = w_d_neg ? ({DATA_W{1'b0}} - in_data)   : in_data;
    assign w_mag_w = w_w_neg ? ({DATA_W{1'b0}} - in_weight) : in_weight;

    // Accumulator arithmetic in a wide signed domain before saturation.
    assign w_acc_ext  = (SIGNED != 0) ? {{(CALC_W-ACC_W){r_acc[ACC_W-1]}}, r_acc}
                                      : {{(CALC_W-ACC_W){1'b0}}, r_acc};
    assign w_part_ext = {{(CALC_W-2*DATA_W){1'b0}}, w_partial};
    assign w_acc_sum  = r_sign ? (w_acc_ext - w_part_ext) : (w_acc_ext + w_part_ext);
    assign w_acc_res  = saturate(w_acc_sum, ACC_W, SIGNED != 0);
    assign w_out_res  = clamp_relu(w_acc_ext, OUT_W, SIGNED != 0, r_relu);
    assign w_unused   = &{1'b0, w_acc_res.val[CALC_W-1:ACC_W], w_out_res.val[CALC_W-1:OUT_W]};

    atom_npu_shift_mul #(
        .DATA_W (DATA_W)
    ) u_shift_mul (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_accept),
        .i_mag_d   (w_mag_d),
        .i_mag_w   (w_mag_w),
        .o_partial (w_partial),
        .o_done    (w_mul_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_LOAD: begin
                if (w_accept) begin
                    w_next_state = ST_MUL;
                end else begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_MUL: begin
                if (w_mul_done) begin
                    w_next_state = ST_ACCUM;
                end else begin
                    w_next_state = ST_MUL;
                end
            end
            ST_ACCUM: begin
                if (r_last) begin
                    w_next_state = ST_FINISH;
                end else begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_FINISH: begin
                w_next_state = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    w_next_state = ST_LOAD;
                end else begin
                    w_next_state = ST_OUT;
                end
            end
            default: begin
                w_next_state = ST_LOAD;
            end
        endcase
    end

    // Per-vector context, accumulator and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_first     <= 1'b1;
            r_sign      <= 1'b0;
            r_last      <= 1'b0;
            r_relu      <= 1'b0;
            r_sat       <= 1'b0;
            r_acc       <= {ACC_W{1'b0}};
            r_out_data  <= {OUT_W{1'b0}};
            r_out_sat   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        r_sign <= w_d_neg ^ w_w_neg;
                        r_last <= in_last;
                        if (r_first) begin
                            r_acc   <= bias_in;
                            r_relu  <= relu_en;
                            r_sat   <= 1'b0;
                            r_first <= 1'b0;
                        end
                    end
                end
                ST_ACCUM: begin
                    r_acc <= w_acc_res.val[ACC_W-1:0];
                    r_sat <= r_sat | w_acc_res.sat;
                end
                ST_FINISH: begin
                    r_out_data  <= w_out_res.val[OUT_W-1:0];
                    r_out_sat   <= r_sat | w_out_res.sat;
                    r_sat       <= r_sat | w_out_res.sat;
                    r_out_valid <= 1'b1;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_first     <= 1'b1;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
